// File: rtl/scarv_cop_mpadd_seq_pkg.sv
// Shared encodings for the multi-precision add/sub sequencer:
// packed-width (pw) encodings understood by the PALU adder, the
// sequencer FSM state encodings, and a helper mapping pw to a lane mask.
package scarv_cop_mpadd_seq_pkg;

    localparam logic [2:0] SCARV_COP_PW_1  = 3'b001; // 1 x 32-bit
    localparam logic [2:0] SCARV_COP_PW_2  = 3'b010; // 2 x 16-bit
    localparam logic [2:0] SCARV_COP_PW_4  = 3'b100; // 4 x 8-bit
    localparam logic [2:0] SCARV_COP_PW_8  = 3'b101; // 8 x 4-bit
    localparam logic [2:0] SCARV_COP_PW_16 = 3'b110; // 16 x 2-bit

    typedef enum logic {
        SCARV_COP_MPADD_IDLE = 1'b0,
        SCARV_COP_MPADD_RUN  = 1'b1
    } mpadd_state_t;

    // Low bits of a bit index that must be zero at the start of a lane.
    function automatic logic [4:0] pw_lane_mask(input logic [2:0] pw);
        case (pw)
            SCARV_COP_PW_2:  pw_lane_mask = 5'd15;
            SCARV_COP_PW_4:  pw_lane_mask = 5'd7;
            SCARV_COP_PW_8:  pw_lane_mask = 5'd3;
            SCARV_COP_PW_16: pw_lane_mask = 5'd1;
            default:         pw_lane_mask = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/scarv_cop_mpadd_seq_if.sv
// Command / operand / result handshake bundle of the mp add/sub sequencer.
// master = requester side, slave = the sequencer.
interface scarv_cop_mpadd_seq_if #(
    parameter int MAX_LEN_W = 4
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_sub;
    logic [MAX_LEN_W-1:0] cmd_len;
    logic                 abort;
    logic                 op_valid;
    logic                 op_ready;
    logic [31:0]          op_a;
    logic [31:0]          op_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_c;
    logic [MAX_LEN_W-1:0] res_idx;
    logic                 res_last;
    logic                 res_co;
    logic                 busy;

    modport master (
        output cmd_valid, cmd_sub, cmd_len, abort, op_valid, op_a, op_b, res_ready,
        input  cmd_ready, op_ready, res_valid, res_c, res_idx, res_last, res_co, busy
    );

    modport slave (
        input  cmd_valid, cmd_sub, cmd_len, abort, op_valid, op_a, op_b, res_ready,
        output cmd_ready, op_ready, res_valid, res_c, res_idx, res_last, res_co, busy
    );
endinterface

// File: rtl/scarv_cop_palu_adder.sv
// Packed-width adder/subtractor. Subtraction inverts rhs; the caller
// supplies ci (1 for a plain subtract). Carries are cut at lane
// boundaries selected by pw and every lane starts from ci. co is the
// carry out of the most significant lane.
module scarv_cop_palu_adder
    import scarv_cop_mpadd_seq_pkg::*;
(
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [2:0]  pw,
    input  logic        sub,
    input  logic        ci,
    output logic [31:0] c,
    output logic        co
);

    logic [31:0] rhs_x;
    logic [32:0] cy;
    logic [4:0]  lane_mask;
    logic        cin_b;

    // Ripple carry chain with lane-boundary carry injection.
    always_comb begin
        lane_mask = pw_lane_mask(pw);
        rhs_x     = sub ? ~rhs : rhs;
        cy        = '0;
        cy[0]     = ci;
        c         = '0;
        cin_b     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cin_b     = ((5'(i) & lane_mask) == 5'd0) ? ci : cy[i];
            c[i]      = lhs[i] ^ rhs_x[i] ^ cin_b;
            cy[i+1]   = (lhs[i] & rhs_x[i]) | (cin_b & (lhs[i] ^ rhs_x[i]));
        end
        co = cy[32];
    end

endmodule

// File: rtl/scarv_cop_mpadd_seq.sv
// Multi-precision add/subtract sequencer. Streams limb pairs LS-first
// through one 32-bit PALU adder, chaining carry in a register, and
// returns one registered result limb per accepted operand pair.
// Optional build macro SCARV_COP_MPADD_CIN_EN adds cmd_cin, an external
// carry/borrow folded into the initial carry (cmd_sub ^ cmd_cin).
module scarv_cop_mpadd_seq
    import scarv_cop_mpadd_seq_pkg::*;
#(
    parameter int MAX_LEN_W = 4
) (
    input  logic g_clk,
    input  logic g_resetn,
`ifdef SCARV_COP_MPADD_CIN_EN
    input  logic cmd_cin,
`endif
    scarv_cop_mpadd_seq_if.slave bus
);

    localparam logic [MAX_LEN_W-1:0] CNT_ONE = {{(MAX_LEN_W-1){1'b0}}, 1'b1};

    mpadd_state_t         state, state_nxt;
    logic                 sub_q;
    logic [MAX_LEN_W-1:0] len_q;
    logic [MAX_LEN_W-1:0] count;
    logic                 carry;
    logic                 carry_init;

    logic                 res_valid_q;
    logic [31:0]          res_c_q;
    logic [MAX_LEN_W-1:0] res_idx_q;
    logic                 res_last_q;
    logic                 res_co_q;

    logic                 cmd_fire;
    logic                 abort_run;
    logic                 op_ready;
    logic                 op_fire;
    logic                 op_last;
    logic [31:0]          add_c;
    logic                 add_co;

`ifdef SCARV_COP_MPADD_CIN_EN
    assign carry_init = bus.cmd_sub ^ cmd_cin;
`else
    assign carry_init = bus.cmd_sub;
`endif

    // Abort beats the operand handshake; a pending result must drain first.
    assign cmd_fire  = (state == SCARV_COP_MPADD_IDLE) && bus.cmd_valid;
    assign abort_run = (state == SCARV_COP_MPADD_RUN) && bus.abort;
    assign op_ready  = (state == SCARV_COP_MPADD_RUN) && !bus.abort &&
                       (!res_valid_q || bus.res_ready);
    assign op_fire   = op_ready && bus.op_valid;
    assign op_last   = (count == len_q);

    scarv_cop_palu_adder u_adder (
        .lhs (bus.op_a),
        .rhs (bus.op_b),
        .pw  (SCARV_COP_PW_1),
        .sub (sub_q),
        .ci  (carry),
        .c   (add_c),
        .co  (add_co)
    );

    // FSM state register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state <= SCARV_COP_MPADD_IDLE;
        else           state <= state_nxt;
    end

    // FSM next-state.
    always_comb begin
        state_nxt = state;
        case (state)
            SCARV_COP_MPADD_IDLE: if (bus.cmd_valid) state_nxt = SCARV_COP_MPADD_RUN;
            SCARV_COP_MPADD_RUN: begin
                if (bus.abort)              state_nxt = SCARV_COP_MPADD_IDLE;
                else if (op_fire && op_last) state_nxt = SCARV_COP_MPADD_IDLE;
            end
            default: state_nxt = SCARV_COP_MPADD_IDLE;
        endcase
    end

    // Command latch, carry chain and limb counter (count stops at len).
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            sub_q <= 1'b0;
            len_q <= '0;
            count <= '0;
            carry <= 1'b0;
        end else if (cmd_fire) begin
            sub_q <= bus.cmd_sub;
            len_q <= bus.cmd_len;
            count <= '0;
            carry <= carry_init;
        end else if (abort_run) begin
            count <= '0;
            carry <= 1'b0;
        end else if (op_fire) begin
            carry <= add_co;
            count <= op_last ? '0 : count + CNT_ONE;
        end
    end

    // Result output register; consume and reload may share a cycle.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            res_valid_q <= 1'b0;
            res_c_q     <= '0;
            res_idx_q   <= '0;
            res_last_q  <= 1'b0;
            res_co_q    <= 1'b0;
        end else if (abort_run) begin
            res_valid_q <= 1'b0;
        end else if (op_fire) begin
            res_valid_q <= 1'b1;
            res_c_q     <= add_c;
            res_idx_q   <= count;
            res_last_q  <= op_last;
            res_co_q    <= add_co;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.cmd_ready = (state == SCARV_COP_MPADD_IDLE);
    assign bus.busy      = (state == SCARV_COP_MPADD_RUN);
    assign bus.op_ready  = op_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_c     = res_c_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.res_last  = res_last_q;
    assign bus.res_co    = res_co_q;

endmodule

// File: tb/tb_scarv_cop_mpadd_seq.sv
// Bench for scarv_cop_mpadd_seq: a wide-integer reference model builds the
// expected limbs per command; each limb is queued at its operand handshake
// and compared by a monitor at the result handshake.
module tb_scarv_cop_mpadd_seq;

    localparam int MAX_LEN_W = 4;
    localparam int NL        = 16;

    typedef struct packed {
        logic [31:0] c;
        logic [3:0]  idx;
        logic        last;
        logic        co;
    } exp_t;

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b0;
`ifdef SCARV_COP_MPADD_CIN_EN
    logic cmd_cin  = 1'b0;
`endif

    always #5 g_clk = ~g_clk;

    scarv_cop_mpadd_seq_if #(.MAX_LEN_W(MAX_LEN_W)) bus ();

    scarv_cop_mpadd_seq #(.MAX_LEN_W(MAX_LEN_W)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
`ifdef SCARV_COP_MPADD_CIN_EN
        .cmd_cin  (cmd_cin),
`endif
        .bus      (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          lasts_seen = 0;
    exp_t        sbq[$];
    exp_t        exp_arr[NL];
    logic [31:0] av[NL];
    logic [31:0] bv[NL];
    exp_t        mon_e;

    // Scoreboard monitor: compare every consumed result limb.
    always @(negedge g_clk) begin
        if (g_resetn && bus.res_valid && bus.res_ready) begin
            if (bus.res_last) lasts_seen++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got c=%h idx=%0d last=%b", bus.res_c, bus.res_idx, bus.res_last);
            end else begin
                mon_e = sbq.pop_front();
                if (bus.res_c !== mon_e.c || bus.res_idx !== mon_e.idx || bus.res_last !== mon_e.last ||
                    (mon_e.last && bus.res_co !== mon_e.co)) begin
                    errors++;
                    $display("FAIL sb_result got c=%h idx=%0d last=%b co=%b want c=%h idx=%0d last=%b co=%b",
                             bus.res_c, bus.res_idx, bus.res_last, bus.res_co,
                             mon_e.c, mon_e.idx, mon_e.last, mon_e.co);
                end
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Reference model over the whole operand width.
    task automatic build_exp(input logic sub, input int n);
        logic [543:0] A, B, R;
        logic         co;
        A = '0;
        B = '0;
        for (int i = 0; i < n; i++) begin
            A[i*32 +: 32] = av[i];
            B[i*32 +: 32] = bv[i];
        end
        if (sub) begin
            R  = A - B;
            co = (A >= B);
        end else begin
            R  = A + B;
            co = R[n*32];
        end
        for (int i = 0; i < n; i++) begin
            exp_arr[i].c    = R[i*32 +: 32];
            exp_arr[i].idx  = 4'(i);
            exp_arr[i].last = (i == n - 1);
            exp_arr[i].co   = co;
        end
    endtask

    task automatic send_cmd(input logic sub, input logic [3:0] len);
        bit ok;
        ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_sub   = sub;
        bus.cmd_len   = len;
        for (int t = 0; t < 50; t++) begin
            @(negedge g_clk);
            if (bus.cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL cmd_timeout cmd_ready stayed %b, required 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_ops(input int start, input int n, output int stalls);
        bit ok;
        stalls = 0;
        for (int i = start; i < start + n; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a     = av[i];
            bus.op_b     = bv[i];
            ok = 0;
            for (int t = 0; t < 100; t++) begin
                @(negedge g_clk);
                if (bus.op_ready) begin ok = 1; break; end
                stalls++;
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL op_timeout limb %0d op_ready stayed %b, required 1", i, bus.op_ready);
            end else begin
                sbq.push_back(exp_arr[i]);
            end
            tick();
        end
        bus.op_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge g_clk);
            if (sbq.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
        tick();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.op_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got cmd_ready=%b op_ready=%b busy=%b want 1 0 0",
                     bus.cmd_ready, bus.op_ready, bus.busy);
        end
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_c !== 32'h0 || bus.res_idx !== 4'h0 ||
            bus.res_last !== 1'b0 || bus.res_co !== 1'b0) begin
            errors++;
            $display("FAIL reset_res got valid=%b c=%h idx=%0d last=%b co=%b want all zero",
                     bus.res_valid, bus.res_c, bus.res_idx, bus.res_last, bus.res_co);
        end
        tick();
        g_resetn = 1'b1;
        tick();
    endtask

    task automatic test_add_single();
        int st;
        av[0] = 32'hFFFF_FFFF; bv[0] = 32'h0000_0001;
        build_exp(1'b0, 1);
        send_cmd(1'b0, 4'd0);
        send_ops(0, 1, st);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_last !== 1'b1 || bus.res_c !== 32'h0 || bus.res_co !== 1'b1) begin
            errors++;
            $display("FAIL add_single_latency got valid=%b last=%b c=%h co=%b want 1 1 00000000 1",
                     bus.res_valid, bus.res_last, bus.res_c, bus.res_co);
        end
        drain();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_single_idle got cmd_ready=%b busy=%b res_valid=%b want 1 0 0",
                     bus.cmd_ready, bus.busy, bus.res_valid);
        end
    endtask

    task automatic test_add_chain();
        int st;
        av[0] = 32'hFFFF_FFFF; bv[0] = 32'h0000_0001;
        av[1] = 32'h0000_0000; bv[1] = 32'h0000_0000;
        build_exp(1'b0, 2);
        send_cmd(1'b0, 4'd1);
        send_ops(0, 2, st);
        drain();
    endtask

    task automatic test_sub();
        int st;
        av[0] = 32'd5; bv[0] = 32'd7;
        build_exp(1'b1, 1);
        send_cmd(1'b1, 4'd0);
        send_ops(0, 1, st);
        checks++;
        if (bus.res_c !== 32'hFFFF_FFFE || bus.res_co !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow got c=%h co=%b want fffffffe 0", bus.res_c, bus.res_co);
        end
        drain();
        av[0] = 32'd7; bv[0] = 32'd5;
        build_exp(1'b1, 1);
        send_cmd(1'b1, 4'd0);
        send_ops(0, 1, st);
        checks++;
        if (bus.res_c !== 32'h0000_0002 || bus.res_co !== 1'b1) begin
            errors++;
            $display("FAIL sub_noborrow got c=%h co=%b want 00000002 1", bus.res_c, bus.res_co);
        end
        drain();
    endtask

    task automatic test_max_len();
        int st;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NL; i++) begin
                av[i] = $urandom();
                bv[i] = (i == 3) ? ~av[i] : $urandom();
            end
            build_exp(k[0], NL);
            send_cmd(k[0], 4'd15);
            send_ops(0, NL, st);
            checks++;
            if (st != 0) begin
                errors++;
                $display("FAIL max_len_throughput got %0d stall cycles want 0", st);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int st;
        for (int i = 0; i < 4; i++) begin av[i] = $urandom(); bv[i] = $urandom(); end
        build_exp(1'b0, 4);
        send_cmd(1'b0, 4'd3);
        send_ops(0, 1, st);
        bus.res_ready = 1'b0;
        bus.op_valid  = 1'b1;
        bus.op_a      = av[1];
        bus.op_b      = bv[1];
        for (int t = 0; t < 3; t++) begin
            @(negedge g_clk);
            checks++;
            if (bus.op_ready !== 1'b0 || bus.res_valid !== 1'b1 ||
                bus.res_c !== exp_arr[0].c || bus.res_idx !== 4'd0) begin
                errors++;
                $display("FAIL bp_hold got op_ready=%b valid=%b c=%h idx=%0d want 0 1 %h 0",
                         bus.op_ready, bus.res_valid, bus.res_c, bus.res_idx, exp_arr[0].c);
            end
            tick();
        end
        bus.res_ready = 1'b1;
        send_ops(1, 3, st);
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL bp_throughput got %0d stall cycles want 0", st);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int   st;
        exp_t held;
        av[0] = $urandom(); bv[0] = $urandom();
        build_exp(1'b1, 1);
        held = exp_arr[0];
        send_cmd(1'b1, 4'd0);
        send_ops(0, 1, st);
        bus.res_ready = 1'b0;
        av[0] = $urandom(); bv[0] = $urandom();
        build_exp(1'b0, 1);
        send_cmd(1'b0, 4'd0);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_c !== held.c || bus.res_last !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pending got valid=%b c=%h last=%b busy=%b want 1 %h 1 1",
                     bus.res_valid, bus.res_c, bus.res_last, bus.busy, held.c);
        end
        bus.res_ready = 1'b1;
        send_ops(0, 1, st);
        drain();
    endtask

    task automatic test_abort();
        int st;
        int lasts_before;
        for (int i = 0; i < 4; i++) begin av[i] = $urandom(); bv[i] = $urandom(); end
        build_exp(1'b0, 4);
        send_cmd(1'b0, 4'd3);
        send_ops(0, 2, st);
        lasts_before  = lasts_seen;
        bus.res_ready = 1'b0;
        bus.op_valid  = 1'b1;
        bus.op_a      = av[2];
        bus.op_b      = bv[2];
        bus.abort     = 1'b1;
        @(negedge g_clk);
        checks++;
        if (bus.op_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_op_ready got %b want 0", bus.op_ready);
        end
        tick();
        bus.abort    = 1'b0;
        bus.op_valid = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state got valid=%b busy=%b cmd_ready=%b want 0 0 1",
                     bus.res_valid, bus.busy, bus.cmd_ready);
        end
        sbq.delete();
        bus.res_ready = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        checks++;
        if (bus.res_valid !== 1'b0 || lasts_seen != lasts_before) begin
            errors++;
            $display("FAIL abort_no_last got valid=%b lasts=%0d want 0 %0d",
                     bus.res_valid, lasts_seen, lasts_before);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_async_reset();
        int st;
        for (int i = 0; i < 4; i++) begin av[i] = $urandom(); bv[i] = $urandom(); end
        build_exp(1'b0, 4);
        send_cmd(1'b0, 4'd3);
        send_ops(0, 2, st);
        #2;
        g_resetn = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.op_ready !== 1'b0 || bus.busy !== 1'b0 ||
            bus.res_valid !== 1'b0 || bus.res_c !== 32'h0 || bus.res_idx !== 4'h0 ||
            bus.res_last !== 1'b0 || bus.res_co !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got cmd_ready=%b op_ready=%b busy=%b valid=%b c=%h idx=%0d last=%b co=%b want 1 0 0 0 0 0 0 0",
                     bus.cmd_ready, bus.op_ready, bus.busy, bus.res_valid,
                     bus.res_c, bus.res_idx, bus.res_last, bus.res_co);
        end
        sbq.delete();
        tick();
        g_resetn = 1'b1;
        tick();
        av[0] = 32'h8000_0000; bv[0] = 32'h8000_0001;
        av[1] = 32'h0000_0010; bv[1] = 32'h0000_0020;
        build_exp(1'b0, 2);
        send_cmd(1'b0, 4'd1);
        send_ops(0, 2, st);
        drain();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_sub   = 1'b0;
        bus.cmd_len   = '0;
        bus.abort     = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b1;
        test_reset();
        test_add_single();
        test_add_chain();
        test_sub();
        test_max_len();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_async_reset();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d queued want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scarv_cop_mpadd_seq.md
Name: scarv_cop_mpadd_seq

Overview:
Multi-precision add/subtract sequencer for the coprocessor. It streams 1..2^MAX_LEN_W 32-bit limb pairs, least-significant first, through one instance of scarv_cop_palu_adder fixed at pw = SCARV_COP_PW_1. It chains the carry between limbs in a register and returns one result limb per accepted operand pair, plus the final carry/borrow. It sits beside the PALU and serves the multi-precision instruction decode path.

Parameters:
MAX_LEN_W, 4, width of the length field; maximum operand size is 2^MAX_LEN_W limbs (default 16 limbs, 512 bits).

Ports:
g_clk  input  1  clock, all state updates on the rising edge
g_resetn  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accept; high only in IDLE
cmd_sub  input  1  1 = subtract (a - b), 0 = add
cmd_len  input  MAX_LEN_W  number of limbs minus 1
abort  input  1  cancel the current operation
op_valid  input  1  operand limb pair valid
op_ready  output  1  operand limb pair accept
op_a  input  32  LHS limb
op_b  input  32  RHS limb
res_valid  output  1  result limb valid
res_ready  input  1  result limb accept
res_c  output  32  result limb
res_idx  output  MAX_LEN_W  limb index of res_c
res_last  output  1  res_c is the final limb
res_co  output  1  final carry out (add) or not-borrow (sub); meaningful only when res_last=1
busy  output  1  state is RUN

Behaviour:
- Reset values: cmd_ready=1, op_ready=0, res_valid=0, res_c=0, res_idx=0, res_last=0, res_co=0, busy=0. Internal state: IDLE, carry=0, count=0.
- FSM IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch sub and len, set count=0, set carry=cmd_sub, go to RUN.
  - Subtraction uses the adder's b-invert with ci=1 on limb 0.
- FSM RUN:
  - op_ready = !abort && (!res_valid || res_ready).
  - On op handshake, drive the adder with a=op_a, b=op_b, sub=latched sub, ci=carry, pw=SCARV_COP_PW_1.
  - Register the result: res_c=c, res_idx=count, res_last=(count==len), res_co=co, res_valid=1. Set carry=co and count=count+1.
  - Latency: the result is visible one cycle after the operand handshake.
  - On the handshake with count==len, go to IDLE. The last result stays in the output register until it is consumed.
- Output register:
  - res_valid clears on res_ready when no new limb is loaded in the same cycle.
  - Consume and reload in the same cycle is allowed, giving full throughput of one limb per cycle.
  - res_c, res_idx, res_last and res_co hold stable while res_valid=1 and res_ready=0.
- New command while the final result is pending:
  - Accepted in IDLE.
  - The output register is untouched until the new command's first operand handshake, which still requires !res_valid || res_ready.
- Abort:
  - In RUN, abort has priority over the operand handshake: op_ready is forced to 0.
  - Next state IDLE; res_valid cleared; carry=0; count=0.
  - A result limb already presented is dropped and no res_last is produced.
  - Abort in IDLE is ignored.
- cmd_len=0: a single limb; res_last=1 on the first result.
- count never wraps: it stops at len, and len <= 2^MAX_LEN_W-1.
- Asynchronous reset mid-operation returns every output and internal state to the reset values immediately.
- Subtract result: res_co=1 means no borrow (a >= b over the full width).

Optional Feature:
SCARV_COP_MPADD_CIN_EN
- Defined: adds input port cmd_cin (1 bit). The initial carry is cmd_sub ^ cmd_cin, so an external carry (add) or borrow (sub) can be chained across commands.
- Undefined: the port is absent and the initial carry is cmd_sub.

Decomposition:
- Shared package/header (scarv_cop_common.vh): the SCARV_COP_PW_* encodings already live there. Add the FSM state encodings SCARV_COP_MPADD_IDLE=1'b0 and SCARV_COP_MPADD_RUN=1'b1.
- One sub-module: scarv_cop_palu_adder, instantiated once with pw tied to SCARV_COP_PW_1.
- The output register stage stays inline.

Test Plan:
1. Add, len=0, a=0xFFFFFFFF, b=0x00000001 -> res_c=0x00000000, res_last=1, res_co=1, result one cycle after the op handshake.
2. Add, len=1, limbs (0xFFFFFFFF,0x00000001) then (0x00000000,0x00000000) -> res_c=0x00000000 idx0, then 0x00000001 idx1 last, res_co=0.
3. Sub, len=0:
   - a=5, b=7 -> res_c=0xFFFFFFFE, res_co=0.
   - a=7, b=5 -> res_c=0x00000002, res_co=1.
4. Backpressure: len=3, res_ready=0 for 3 cycles after the first result -> op_ready=0 and res_c/res_idx held; once released, 4 limbs complete with one result per cycle.
5. Abort asserted with op_valid=1 after limb 1 of len=3 -> op_ready=0 that cycle, next cycle res_valid=0, busy=0, cmd_ready=1; no res_last is ever seen.
6. g_resetn pulled low mid-RUN between clock edges -> all outputs at reset values without a clock edge; a new command afterwards produces correct results from limb 0.
